// File: rtl/comparator_1bit.sv
// Single-bit magnitude comparator with registered one-hot eq/gt/lt result.
// Optional saturating per-outcome counters are built when COMPARATOR_1BIT_COUNTERS_EN is defined.
module comparator_1bit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             cnt_en,
    input  logic             cnt_clr,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic             out_valid,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt
);

    logic eq_c, gt_c, lt_c;
    logic eq_p1, gt_p1, lt_p1, vld_p1;

    assign eq_c = ~(a ^ b);
    assign gt_c = a & ~b;
    assign lt_c = ~a & b;

    // Stage p1: registered compare result
    always_ff @(posedge clk) begin
        if (rst) begin
            eq_p1  <= 1'b0;
            gt_p1  <= 1'b0;
            lt_p1  <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            eq_p1  <= eq_c;
            gt_p1  <= gt_c;
            lt_p1  <= lt_c;
            vld_p1 <= 1'b1;
        end
    end

    assign eq        = eq_p1;
    assign gt        = gt_p1;
    assign lt        = lt_p1;
    assign out_valid = vld_p1;

`ifdef COMPARATOR_1BIT_COUNTERS_EN
    logic [CNT_W-1:0] eq_cnt_p1, gt_cnt_p1, lt_cnt_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Stage p1: counters count the combinational outcome of the sampled operands
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            eq_cnt_p1 <= '0;
            gt_cnt_p1 <= '0;
            lt_cnt_p1 <= '0;
        end else if (cnt_en) begin
            if (eq_c) eq_cnt_p1 <= sat_inc(eq_cnt_p1);
            if (gt_c) gt_cnt_p1 <= sat_inc(gt_cnt_p1);
            if (lt_c) lt_cnt_p1 <= sat_inc(lt_cnt_p1);
        end
    end

    assign eq_cnt = eq_cnt_p1;
    assign gt_cnt = gt_cnt_p1;
    assign lt_cnt = lt_cnt_p1;
`else
    logic unused_cnt_ctrl;
    assign unused_cnt_ctrl = cnt_en ^ cnt_clr;

    assign eq_cnt = '0;
    assign gt_cnt = '0;
    assign lt_cnt = '0;
`endif

endmodule

// File: tb/tb_comparator_1bit.sv
// Self-checking bench for comparator_1bit: directed scenarios plus random stimulus against a model.
// Two instances (CNT_W=16 and CNT_W=2) share the inputs so saturation is reachable quickly.
module tb_comparator_1bit;

`ifdef COMPARATOR_1BIT_COUNTERS_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a = 1'b0, b = 1'b0, cnt_en = 1'b0, cnt_clr = 1'b0;

    logic eq16, gt16, lt16, vld16;
    logic eq2, gt2, lt2, vld2;
    logic [15:0] eqc16, gtc16, ltc16;
    logic [1:0]  eqc2, gtc2, ltc2;

    int total = 0;
    int bad   = 0;

    // Reference model: outcome flags {eq,gt,lt,valid} and plain integer counts
    logic [3:0] m_flags = 4'b0000;
    int m16[3] = '{0, 0, 0};
    int m2[3]  = '{0, 0, 0};

    comparator_1bit #(.CNT_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .a(a), .b(b), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
        .eq(eq16), .gt(gt16), .lt(lt16), .out_valid(vld16),
        .eq_cnt(eqc16), .gt_cnt(gtc16), .lt_cnt(ltc16)
    );

    comparator_1bit #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .a(a), .b(b), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
        .eq(eq2), .gt(gt2), .lt(lt2), .out_valid(vld2),
        .eq_cnt(eqc2), .gt_cnt(gtc2), .lt_cnt(ltc2)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] exp16();
        if (!CNT_ON) return '0;
        return {16'(m16[0]), 16'(m16[1]), 16'(m16[2])};
    endfunction

    function automatic logic [5:0] exp2();
        if (!CNT_ON) return '0;
        return {2'(m2[0]), 2'(m2[1]), 2'(m2[2])};
    endfunction

    // Drive one cycle of stimulus, advance the model, settle just after the edge
    task automatic step(input logic ia, input logic ib, input logic ien,
                        input logic iclr, input logic irst);
        int k;
        @(negedge clk);
        a = ia; b = ib; cnt_en = ien; cnt_clr = iclr; rst = irst;
        @(posedge clk);
        k = (ia == ib) ? 0 : ((ia > ib) ? 1 : 2);
        if (irst) begin
            m_flags = 4'b0000;
            m16 = '{0, 0, 0};
            m2  = '{0, 0, 0};
        end else begin
            m_flags = (k == 0) ? 4'b1001 : ((k == 1) ? 4'b0101 : 4'b0011);
            if (iclr) begin
                m16 = '{0, 0, 0};
                m2  = '{0, 0, 0};
            end else if (ien) begin
                m16[k] = (m16[k] + 1 > 65535) ? 65535 : m16[k] + 1;
                m2[k]  = (m2[k] + 1 > 3) ? 3 : m2[k] + 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            total++;
            if ({eq16, gt16, lt16, vld16, eq2, gt2, lt2, vld2} !== 8'b0) begin
                bad++;
                $display("FAIL reset_flags: got %b want 00000000",
                         {eq16, gt16, lt16, vld16, eq2, gt2, lt2, vld2});
            end
            total++;
            if ({eqc16, gtc16, ltc16, eqc2, gtc2, ltc2} !== 54'b0) begin
                bad++;
                $display("FAIL reset_counts: got %h want 0",
                         {eqc16, gtc16, ltc16, eqc2, gtc2, ltc2});
            end
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if ({eq16, gt16, lt16, vld16} !== 4'b0101) begin
            bad++;
            $display("FAIL reset_release: got %b want 0101", {eq16, gt16, lt16, vld16});
        end
    endtask

    task automatic test_exhaustive();
        logic [3:0] want[4] = '{4'b1001, 4'b0011, 4'b0101, 4'b1001};
        for (int i = 0; i < 4; i++) begin
            step(i[1], i[0], 1'b0, 1'b0, 1'b0);
            total++;
            if ({eq16, gt16, lt16, vld16} !== want[i] || {eq2, gt2, lt2, vld2} !== want[i]) begin
                bad++;
                $display("FAIL exhaustive a=%0d b=%0d: got %b/%b want %b",
                         i[1], i[0], {eq16, gt16, lt16, vld16}, {eq2, gt2, lt2, vld2}, want[i]);
            end
        end
    endtask

    task automatic test_counting();
        logic [47:0] want16;
        logic [5:0]  want2;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        want16 = CNT_ON ? {16'd3, 16'd2, 16'd1} : 48'd0;
        want2  = CNT_ON ? {2'd3, 2'd2, 2'd1} : 6'd0;
        total++;
        if ({eqc16, gtc16, ltc16} !== want16 || {eqc2, gtc2, ltc2} !== want2) begin
            bad++;
            $display("FAIL counting: got %h/%b want %h/%b",
                     {eqc16, gtc16, ltc16}, {eqc2, gtc2, ltc2}, want16, want2);
        end
        for (int i = 0; i < 4; i++) begin
            step(i[0], i[1], 1'b0, 1'b0, 1'b0);
            total++;
            if ({eqc16, gtc16, ltc16} !== want16 || {eqc2, gtc2, ltc2} !== want2) begin
                bad++;
                $display("FAIL count_hold cycle %0d: got %h/%b want %h/%b", i,
                         {eqc16, gtc16, ltc16}, {eqc2, gtc2, ltc2}, want16, want2);
            end
        end
    endtask

    task automatic test_saturation_clear();
        int w16, w2;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            w16 = CNT_ON ? i : 0;
            w2  = CNT_ON ? ((i > 3) ? 3 : i) : 0;
            total++;
            if (eqc16 !== 16'(w16) || eqc2 !== 2'(w2)) begin
                bad++;
                $display("FAIL saturate cycle %0d: got %0d/%0d want %0d/%0d",
                         i, eqc16, eqc2, w16, w2);
            end
        end
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        total++;
        if ({eqc16, gtc16, ltc16, eqc2, gtc2, ltc2} !== 54'b0) begin
            bad++;
            $display("FAIL clear_over_en: got %h want 0",
                     {eqc16, gtc16, ltc16, eqc2, gtc2, ltc2});
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if (eqc2 !== 2'(CNT_ON ? 1 : 0)) begin
            bad++;
            $display("FAIL count_after_clear: got %0d want %0d", eqc2, CNT_ON ? 1 : 0);
        end
    endtask

    task automatic test_mid_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        total++;
        if ({eq16, gt16, lt16, vld16} !== 4'b0000 ||
            {eqc16, gtc16, ltc16, eqc2, gtc2, ltc2} !== 54'b0) begin
            bad++;
            $display("FAIL mid_reset: got flags %b counts %h want 0000 / 0",
                     {eq16, gt16, lt16, vld16}, {eqc16, gtc16, ltc16, eqc2, gtc2, ltc2});
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if ({eq16, gt16, lt16, vld16} !== 4'b0011 || ltc16 !== 16'(CNT_ON ? 1 : 0)) begin
            bad++;
            $display("FAIL after_mid_reset: got flags %b lt_cnt %0d want 0011 %0d",
                     {eq16, gt16, lt16, vld16}, ltc16, CNT_ON ? 1 : 0);
        end
    endtask

    task automatic test_random();
        logic ra, rb, ren, rclr, rrst;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            ra   = 1'($urandom);
            rb   = 1'($urandom);
            ren  = ($urandom_range(0, 3) != 0);
            rclr = ($urandom_range(0, 15) == 0);
            rrst = ($urandom_range(0, 63) == 0);
            step(ra, rb, ren, rclr, rrst);
            total++;
            if ({eq16, gt16, lt16, vld16} !== m_flags || {eq2, gt2, lt2, vld2} !== m_flags) begin
                bad++;
                $display("FAIL random_flags cycle %0d: got %b/%b want %b", i,
                         {eq16, gt16, lt16, vld16}, {eq2, gt2, lt2, vld2}, m_flags);
            end
            total++;
            if ({eqc16, gtc16, ltc16} !== exp16() || {eqc2, gtc2, ltc2} !== exp2()) begin
                bad++;
                $display("FAIL random_counts cycle %0d: got %h/%b want %h/%b", i,
                         {eqc16, gtc16, ltc16}, {eqc2, gtc2, ltc2}, exp16(), exp2());
            end
        end
    endtask

    initial begin
        test_reset();
        test_exhaustive();
        test_counting();
        test_saturation_clear();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/comparator_1bit.md
# comparator_1bit

Single-bit magnitude comparator with registered one-hot result (`eq`, `gt`, `lt`) and optional saturating per-outcome event counters. It is a leaf utility used as the bit-slice building block for wider comparators and as a simple match/ordering monitor on single-bit control signals.

## Interface
Parameters:
- `CNT_W`, default 16: width of each event counter, minimum 1.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `a`  input  1  first operand.
- `b`  input  1  second operand.
- `cnt_en`  input  1  when 1, the outcome of the current compare is counted.
- `cnt_clr`  input  1  synchronous clear of all counters.
- `eq`  output  1  registered: 1 when a == b.
- `gt`  output  1  registered: 1 when a=1, b=0.
- `lt`  output  1  registered: 1 when a=0, b=1.
- `out_valid`  output  1  1 from the first post-reset result onward.
- `eq_cnt`  output  CNT_W  number of counted eq outcomes.
- `gt_cnt`  output  CNT_W  number of counted gt outcomes.
- `lt_cnt`  output  CNT_W  number of counted lt outcomes.

## Operation
- Compare every cycle: eq = ~(a^b), gt = a & ~b, lt = ~a & b.
- Truth table: (0,0) -> eq; (0,1) -> lt; (1,0) -> gt; (1,1) -> eq.
- After reset, exactly one of eq/gt/lt is 1 whenever out_valid = 1.
- Counters: on a rising edge with cnt_en=1, the counter matching the combinational outcome of the sampled a,b increments by 1.
- Counters saturate at 2^CNT_W-1; no wrap.
- cnt_clr=1 zeroes all three counters, overriding any increment that cycle.
- rst overrides cnt_clr and cnt_en.
- X/Z on a or b is not defined; inputs must be driven 0/1.

## Timing
- Latency: 1 cycle. a,b sampled at rising edge N; eq/gt/lt valid after edge N.
- A bench that changes inputs and checks 1 full clock period later sees the new result.
- out_valid: 0 during and immediately after reset; 1 after the first rising edge with rst=0; stays 1 until next reset.
- Counter outputs reflect increments with the same 1-cycle latency as eq/gt/lt.
- Reset values: eq=0, gt=0, lt=0, out_valid=0, all counters 0.
- Reset asserted mid-operation: all outputs take reset values on that edge; counts are lost.
- Simultaneous cnt_clr and cnt_en: counters 0 after the edge.
- Counter at saturation with cnt_en=1: holds value.

## Configuration
- Macro `COMPARATOR_1BIT_COUNTERS_EN`.
- Defined: counter logic and cnt_en/cnt_clr behaviour as above.
- Not defined: no counter registers built. eq_cnt/gt_cnt/lt_cnt are tied to 0. cnt_en/cnt_clr are ignored. Port list is unchanged.
- Compare path, latency and out_valid are identical in both builds.

## Test plan
- Exhaustive compare: after reset, apply (0,0),(0,1),(1,0),(1,1), one per clock. Check one cycle later: eq/gt/lt = 100, 001, 010, 100. out_valid=1 for each check.
- Reset values: hold rst=1 for 2 cycles with a=1,b=0. All outputs are 0 and out_valid=0. Release rst; after 1 edge, gt=1 and out_valid=1.
- Counting (macro defined, CNT_W=16): cnt_en=1; apply (0,0)x3, (1,0)x2, (0,1)x1. Result: eq_cnt=3, gt_cnt=2, lt_cnt=1. Then cnt_en=0 for 4 cycles: counts unchanged.
- Saturation and clear (CNT_W=2): cnt_en=1, a=b=1 for 5 cycles. eq_cnt=3 and holds. Assert cnt_clr with cnt_en=1: eq_cnt=0 next cycle.
- Mid-operation reset: with counts nonzero, pulse rst for 1 cycle. All outputs and counts become 0. The next compare result appears 1 cycle after rst deasserts.
- Macro undefined: repeat the counting scenario. Counters read 0 throughout; eq/gt/lt results are identical to the exhaustive compare scenario.
